uart_rx_oversampler: RTL and testbench



---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_rx_sync2.sv | 33 +++
 rtl/uart_rx_oversampler.sv | 140 ++++++++++++++
 tb/tb_uart_rx_oversampler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_pkg
// Shared constants and helpers for the UART receiver sampling path.
//   PRESCALE_MIN     : smallest oversampling ratio; smaller values are clamped
//   PRESCALE_W_DEF   : default width of prescale / edge counter
//   NUM_SAMPLES_MIN/MAX : legal range of samples taken per bit (odd values)
//   maj_thresh(n)    : a vote is '1' when more than maj_thresh(n) samples are 1
// ----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int PRESCALE_MIN    = 8;
    localparam int PRESCALE_W_DEF  = 6;
    localparam int NUM_SAMPLES_MIN = 3;
    localparam int NUM_SAMPLES_MAX = 7;

    function automatic int maj_thresh(input int n);
        return n / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// ----------------------------------------------------------------------------
// uart_rx_sync2
// Two-flop synchroniser for the asynchronous RX line. Both flops reset to 1
// so the line reads idle while the receiver comes out of reset.
// Only compiled when UART_RX_SYNC_EN is defined, which is also the only
// configuration that instantiates it.
//   clk : receiver clock
//   rst : asynchronous active-low reset
//   d   : raw asynchronous input
//   q   : synchronised output, two clocks behind d
// ----------------------------------------------------------------------------
`ifdef UART_RX_SYNC_EN
module uart_rx_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`endif

// File: rtl/uart_rx_oversampler.sv
// ----------------------------------------------------------------------------
// uart_rx_oversampler
// Majority-vote bit sampler for the UART receiver. Counts clock edges within
// each bit period (prescale clocks per bit), takes NUM_SAMPLES samples centred
// on the middle of the bit and strobes the voted value plus a noise flag.
//
// Build option: UART_RX_SYNC_EN -- when defined, rx_in passes through a
// two-flop synchroniser (2 clocks of latency) before sampling; otherwise the
// line is assumed to be synchronous already and is sampled directly.
//
// Ports:
//   clk          : receiver oversampling clock
//   rst          : asynchronous active-low reset
//   rx_in        : serial RX line
//   prescale     : clocks per bit (values below 8 behave as 8)
//   samp_en      : sampler enable from the RX FSM
//   bit_start    : one-cycle pulse aligning edge 0 to a bit boundary
//   edge_count   : current edge position within the bit
//   bit_done     : high on the last edge of a bit period (combinational)
//   sampled_bit  : voted bit value (idle '1' out of reset)
//   sample_valid : one-cycle strobe, sampled_bit / noise_err just updated
//   noise_err    : samples of the latest bit were not unanimous
// ----------------------------------------------------------------------------
module uart_rx_oversampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W  = PRESCALE_W_DEF,
    parameter int NUM_SAMPLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  samp_en,
    input  logic                  bit_start,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic                  bit_done,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  noise_err
);

    localparam int OW = $clog2(NUM_SAMPLES + 1);

    localparam logic [PRESCALE_W-1:0] PRE_MIN     = PRESCALE_W'(PRESCALE_MIN);
    localparam logic [PRESCALE_W-1:0] ONE_EDGE    = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] HALF_WIN    = PRESCALE_W'((NUM_SAMPLES - 1) / 2);
    localparam logic [OW-1:0]         VOTE_THRESH = OW'(maj_thresh(NUM_SAMPLES));
    localparam logic [OW-1:0]         ALL_SAMPLES = OW'(NUM_SAMPLES);

    if (NUM_SAMPLES < NUM_SAMPLES_MIN || NUM_SAMPLES > NUM_SAMPLES_MAX ||
        (NUM_SAMPLES % 2) == 0) begin : g_bad_num_samples
        $error("uart_rx_oversampler: NUM_SAMPLES must be 3, 5 or 7");
    end

    logic                  rx_s;
    logic [PRESCALE_W-1:0] pre_q;
    logic                  en_q;       // samp_en last cycle; low means idle
    logic [OW-1:0]         ones_cnt;

    `ifdef UART_RX_SYNC_EN
    uart_rx_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );
    `else
    assign rx_s = rx_in;
    `endif

    // Window geometry, derived from the latched ratio so a prescale change
    // in the middle of a bit cannot move the window.
    logic [PRESCALE_W-1:0] pre_clamped;
    logic [PRESCALE_W-1:0] centre;
    logic [PRESCALE_W-1:0] win_first;
    logic [PRESCALE_W-1:0] win_last;
    logic [PRESCALE_W-1:0] period_end;
    logic                  in_window;
    logic                  at_win_last;
    logic                  at_period_end;
    logic [OW-1:0]         ones_total;

    assign pre_clamped   = (prescale < PRE_MIN) ? PRE_MIN : prescale;
    assign centre        = pre_q >> 1;
    assign win_first     = centre - HALF_WIN;
    assign win_last      = centre + HALF_WIN;
    assign period_end    = pre_q - ONE_EDGE;
    assign in_window     = (edge_count >= win_first) && (edge_count <= win_last);
    assign at_win_last   = (edge_count == win_last);
    assign at_period_end = (edge_count == period_end);
    // Includes the sample being taken on the last window edge itself.
    assign ones_total    = ones_cnt + OW'(rx_s);

    assign bit_done = samp_en && at_period_end;

    // NOTE: every register below uses non-blocking assignment so all state
    // updates see the same pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_count   <= '0;
            ones_cnt     <= '0;
            pre_q        <= PRE_MIN;
            en_q         <= 1'b0;
            sample_valid <= 1'b0;
            sampled_bit  <= 1'b1;
            noise_err    <= 1'b0;
        end else begin
            en_q         <= samp_en;
            sample_valid <= 1'b0;

            if (bit_start) begin
                // Realignment wins over wrap and sampling; a vote due on
                // this edge is dropped.
                edge_count <= '0;
                ones_cnt   <= '0;
                pre_q      <= pre_clamped;
            end else if (!samp_en) begin
                edge_count <= '0;
                ones_cnt   <= '0;
            end else begin
                if (!en_q) begin
                    pre_q <= pre_clamped;
                end

                edge_count <= at_period_end ? '0 : edge_count + ONE_EDGE;

                if (at_win_last) begin
                    sampled_bit  <= (ones_total > VOTE_THRESH);
                    noise_err    <= (ones_total != '0) && (ones_total != ALL_SAMPLES);
                    sample_valid <= 1'b1;
                    ones_cnt     <= '0;
                end else if (in_window) begin
                    ones_cnt <= ones_total;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_oversampler
// Drives three samplers (NUM_SAMPLES = 3, 5, 7) from the same stimulus and
// compares them against a window-vote model computed from the bit period:
// centre = max(prescale,8)/2, window = centre +/- (N-1)/2, strobe one cycle
// after the last window edge.
// ----------------------------------------------------------------------------
module tb_uart_rx_oversampler;

    localparam int PW = 6;
    localparam int NI = 3;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          rx_in     = 1'b1;
    logic          samp_en   = 1'b0;
    logic          bit_start = 1'b0;
    logic [PW-1:0] prescale  = PW'(8);

    logic [PW-1:0] ec [NI];
    logic          bd [NI];
    logic          sb [NI];
    logic          sv [NI];
    logic          ne [NI];

    int checks = 0;
    int fails  = 0;

    logic [63:0] pats [4];
    logic        last_bit   [NI];
    logic        last_noise [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_rx_oversampler #(
            .PRESCALE_W  (PW),
            .NUM_SAMPLES (3 + 2 * g)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .rx_in        (rx_in),
            .prescale     (prescale),
            .samp_en      (samp_en),
            .bit_start    (bit_start),
            .edge_count   (ec[g]),
            .bit_done     (bd[g]),
            .sampled_bit  (sb[g]),
            .sample_valid (sv[g]),
            .noise_err    (ne[g])
        );
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int n_of(input int g);
        return 3 + 2 * g;
    endfunction

    function automatic int peff(input int p);
        return (p < 8) ? 8 : p;
    endfunction

    // Returns {vote, noise} for one bit period of line values.
    function automatic logic [1:0] model(input logic [63:0] pat, input int p, input int n);
        int c;
        int h;
        int ones;
        c    = peff(p) / 2;
        h    = (n - 1) / 2;
        ones = 0;
        for (int e = c - h; e <= c + h; e++) ones += int'(pat[e]);
        return {ones > n / 2, (ones != 0) && (ones != n)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle (away from the active edge) and settle.
    task automatic step(input logic bs, input logic en, input logic rx);
        @(negedge clk);
        bit_start = bs;
        samp_en   = en;
        rx_in     = rx;
        #1;
    endtask

    // bit_start, then nbits full bit periods using pats[0..nbits-1], then one
    // extra cycle so a strobe landing on edge 0 of the next bit is seen.
    task automatic run_bits(input int p, input int nbits, input logic en0, input string tag);
        int pe;
        int e;
        int b;
        int n;
        int lst;
        logic exp_sv;
        logic [1:0] v;
        pe = peff(p);
        prescale = PW'(p);
        step(1'b1, en0, 1'b1);
        for (int k = 0; k <= nbits * pe; k++) begin
            e = k % pe;
            b = k / pe;
            step(1'b0, 1'b1, (b < nbits) ? pats[b][e] : 1'b1);
            for (int g = 0; g < NI; g++) begin
                n   = n_of(g);
                lst = pe / 2 + (n - 1) / 2;
                exp_sv = (k >= 1) && (((k - 1) % pe) == lst);
                check($sformatf("%s n%0d k%0d edge_count", tag, n, k), 32'(ec[g]), 32'(e));
                check($sformatf("%s n%0d k%0d bit_done", tag, n, k), 32'(bd[g]), 32'(e == pe - 1));
                check($sformatf("%s n%0d k%0d sample_valid", tag, n, k), 32'(sv[g]), 32'(exp_sv));
                if (exp_sv) begin
                    v = model(pats[(k - 1) / pe], p, n);
                    last_bit[g]   = v[1];
                    last_noise[g] = v[0];
                    check($sformatf("%s n%0d bit", tag, n), 32'(sb[g]), 32'(v[1]));
                    check($sformatf("%s n%0d noise", tag, n), 32'(ne[g]), 32'(v[0]));
                end
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("%s n%0d edge_count", tag, n_of(g)), 32'(ec[g]), 32'd0);
            check($sformatf("%s n%0d sample_valid", tag, n_of(g)), 32'(sv[g]), 32'd0);
            check($sformatf("%s n%0d noise_err", tag, n_of(g)), 32'(ne[g]), 32'd0);
            check($sformatf("%s n%0d sampled_bit", tag, n_of(g)), 32'(sb[g]), 32'd1);
            check($sformatf("%s n%0d bit_done", tag, n_of(g)), 32'(bd[g]), 32'd0);
            last_bit[g]   = 1'b1;
            last_noise[g] = 1'b0;
        end
    endtask

    initial begin
        int p;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b1;

        // Prescale 16, line held low: window 7..9 for N=3, strobe after edge 9.
        pats[0] = '0;
        pats[1] = '0;
        run_bits(16, 2, 1'b0, "p16_low");

        // Prescale 8, line high with a single low glitch at edge 4.
        pats[0] = '1;
        pats[0][4] = 1'b0;
        pats[1] = '1;
        run_bits(8, 2, 1'b1, "p8_glitch");

        // Prescale 32, window 13..19 holds four 0s and three 1s.
        pats[0] = '1;
        for (int e = 13; e <= 19; e++) pats[0][e] = ((e - 13) % 2) == 1;
        pats[1] = {$urandom(), $urandom()};
        run_bits(32, 2, 1'b1, "p32_split");

        // Prescale 4 behaves as 8.
        pats[0] = {$urandom(), $urandom()};
        pats[1] = {$urandom(), $urandom()};
        run_bits(4, 2, 1'b0, "p4_clamp");

        // Random ratios (some below the clamp) and random line patterns.
        for (int i = 0; i < 6; i++) begin
            p = int'($urandom_range(63, 2));
            pats[0] = {$urandom(), $urandom()};
            pats[1] = {$urandom(), $urandom()};
            run_bits(p, 2, 1'($urandom_range(1, 0)), $sformatf("rand%0d_p%0d", i, p));
        end

        // bit_start on the N=3 last window edge (edge 9 at prescale 16) drops
        // that vote; then samp_en falls mid-bit.
        prescale = PW'(16);
        step(1'b1, 1'b1, 1'b1);
        for (int k = 0; k <= 8; k++) begin
            step(1'b0, 1'b1, 1'($urandom_range(1, 0)));
            for (int g = 0; g < NI; g++)
                check($sformatf("bs_at_L k%0d n%0d edge_count", k, n_of(g)), 32'(ec[g]), 32'(k));
        end
        step(1'b1, 1'b1, 1'b0);
        for (int g = 0; g < NI; g++)
            check($sformatf("bs_at_L n%0d edge_count", n_of(g)), 32'(ec[g]), 32'd9);
        step(1'b0, 1'b1, 1'b0);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("bs_at_L n%0d realigned", n_of(g)), 32'(ec[g]), 32'd0);
            check($sformatf("bs_at_L n%0d no strobe", n_of(g)), 32'(sv[g]), 32'd0);
        end
        for (int k = 1; k <= 4; k++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int g = 0; g < NI; g++)
            check($sformatf("en_drop n%0d bit_done", n_of(g)), 32'(bd[g]), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("en_drop n%0d edge_count", n_of(g)), 32'(ec[g]), 32'd0);
            check($sformatf("en_drop n%0d sample_valid", n_of(g)), 32'(sv[g]), 32'd0);
            check($sformatf("en_drop n%0d sampled_bit", n_of(g)), 32'(sb[g]), 32'(last_bit[g]));
            check($sformatf("en_drop n%0d noise_err", n_of(g)), 32'(ne[g]), 32'(last_noise[g]));
        end

        // Reset asserted at edge 8 of a low bit, then a clean vote afterwards.
        prescale = PW'(16);
        step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k <= 8; k++) step(1'b0, 1'b1, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        check_reset_values("mid_reset");
        step(1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        pats[0] = {$urandom(), $urandom()};
        pats[1] = {$urandom(), $urandom()};
        run_bits(16, 2, 1'b1, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
